// File: rtl/mem_req_sequencer.sv
// mem_req_sequencer: buffers load/store requests in a small FIFO and issues them
// one at a time to the AXI-Lite master wrapper, returning one tagged response
// per request and flagging transactions that exceed the completion timeout.
module mem_req_sequencer #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TW      = 4,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [AW-1:0]          req_addr,
  input  logic [DW-1:0]          req_wdata,
  input  logic [TW-1:0]          req_tag,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_we,
  output logic [TW-1:0]          rsp_tag,
  output logic [DW-1:0]          rsp_rdata,
  output logic                   m_exec,
  output logic                   m_we,
  output logic [AW-1:0]          m_address,
  output logic [DW-1:0]          m_data,
  input  logic                   m_fin,
  input  logic [DW-1:0]          m_rdata,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [PW:0]   FULL    = (PW+1)'(DEPTH);
  localparam logic [CW-1:0] TMO_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [TW-1:0] tag;
  } req_t;

  // Request FIFO
  req_t        fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          push;
  logic          pop;
  req_t          head;

  // Sequencer state and registered outputs
  state_t        state, state_nxt;
  logic          m_exec_nxt;
  logic          m_we_nxt;
  logic [AW-1:0] m_address_nxt;
  logic [DW-1:0] m_data_nxt;
  logic [TW-1:0] cur_tag, cur_tag_nxt;
  logic          rsp_valid_nxt;
  logic          rsp_we_nxt;
  logic [TW-1:0] rsp_tag_nxt;
  logic [DW-1:0] rsp_rdata_nxt;
  logic [CW-1:0] tmo_cnt, tmo_cnt_nxt;
  logic          timeout_err_nxt;

  assign req_ready = (count != FULL);
  assign push      = req_valid && req_ready;
  assign head      = fifo_mem[rd_ptr];
  assign level     = count;
  assign busy      = (count != '0) || (state != S_IDLE) || rsp_valid;

  // FIFO storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{we: req_we, addr: req_addr, wdata: req_wdata, tag: req_tag};
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Next-state and next-output logic: issue, wait for fin, hold response
  always_comb begin
    state_nxt       = state;
    pop             = 1'b0;
    m_exec_nxt      = 1'b0;
    m_we_nxt        = m_we;
    m_address_nxt   = m_address;
    m_data_nxt      = m_data;
    cur_tag_nxt     = cur_tag;
    rsp_valid_nxt   = rsp_valid;
    rsp_we_nxt      = rsp_we;
    rsp_tag_nxt     = rsp_tag;
    rsp_rdata_nxt   = rsp_rdata;
    tmo_cnt_nxt     = tmo_cnt;
    timeout_err_nxt = timeout_err;

    if (rsp_valid && rsp_ready) begin
      rsp_valid_nxt = 1'b0;
    end

    case (state)
      S_IDLE: begin
        // A held response blocks the next issue
        if ((count != '0) && !rsp_valid) begin
          pop           = 1'b1;
          m_exec_nxt    = 1'b1;
          m_we_nxt      = head.we;
          m_address_nxt = head.addr;
          m_data_nxt    = head.wdata;
          cur_tag_nxt   = head.tag;
          state_nxt     = S_ISSUE;
        end
      end

      S_ISSUE: begin
        tmo_cnt_nxt = '0;
        state_nxt   = S_WAIT;
      end

      S_WAIT: begin
        if (m_fin) begin
          rsp_valid_nxt = 1'b1;
          rsp_we_nxt    = m_we;
          rsp_tag_nxt   = cur_tag;
          rsp_rdata_nxt = m_we ? '0 : m_rdata;
          tmo_cnt_nxt   = '0;
          m_we_nxt      = 1'b0;
          m_address_nxt = '0;
          m_data_nxt    = '0;
          cur_tag_nxt   = '0;
          state_nxt     = S_IDLE;
        end else begin
          // The wrapper cannot abort, so keep waiting and just flag the overrun
          if (tmo_cnt != TMO_MAX) begin
            tmo_cnt_nxt = tmo_cnt + 1'b1;
          end
          if (tmo_cnt_nxt == TMO_MAX) begin
            timeout_err_nxt = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      m_exec      <= 1'b0;
      m_we        <= 1'b0;
      m_address   <= '0;
      m_data      <= '0;
      cur_tag     <= '0;
      rsp_valid   <= 1'b0;
      rsp_we      <= 1'b0;
      rsp_tag     <= '0;
      rsp_rdata   <= '0;
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      m_exec      <= m_exec_nxt;
      m_we        <= m_we_nxt;
      m_address   <= m_address_nxt;
      m_data      <= m_data_nxt;
      cur_tag     <= cur_tag_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_we      <= rsp_we_nxt;
      rsp_tag     <= rsp_tag_nxt;
      rsp_rdata   <= rsp_rdata_nxt;
      tmo_cnt     <= tmo_cnt_nxt;
      timeout_err <= timeout_err_nxt;
    end
  end

endmodule

// File: tb/tb_mem_req_sequencer.sv
// Bench for mem_req_sequencer: a wrapper/memory model answers m_exec, a
// scoreboard queue holds expected responses and a monitor checks them.
`timescale 1ns/1ps
module tb_mem_req_sequencer;

  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;
  localparam int unsigned TW      = 4;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [TW-1:0] req_tag;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_we;
  logic [TW-1:0] rsp_tag;
  logic [DW-1:0] rsp_rdata;
  logic          m_exec;
  logic          m_we;
  logic [AW-1:0] m_address;
  logic [DW-1:0] m_data;
  logic          m_fin;
  logic [DW-1:0] m_rdata;
  logic          busy;
  logic          timeout_err;
  logic [$clog2(DEPTH):0] level;

  logic fin_model;
  logic stray_fin;
  assign m_fin = fin_model | stray_fin;

  mem_req_sequencer #(
    .AW(AW), .DW(DW), .TW(TW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
    .rsp_tag(rsp_tag), .rsp_rdata(rsp_rdata),
    .m_exec(m_exec), .m_we(m_we), .m_address(m_address), .m_data(m_data),
    .m_fin(m_fin), .m_rdata(m_rdata),
    .busy(busy), .timeout_err(timeout_err), .level(level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          we;
    logic [TW-1:0] tag;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  logic [31:0] mem [logic [31:0]];

  int n_checks = 0;
  int n_err    = 0;
  int n_exec   = 0;
  int n_rsp    = 0;
  int cyc      = 0;
  int exec_cyc = 0;
  int fin_delay;
  bit fin_hold;
  bit outstanding;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Wrapper + memory model: answers each m_exec with a fin after fin_delay cycles
  logic        t_we;
  logic [31:0] t_addr;
  logic [31:0] t_data;
  int          k;
  initial begin
    fin_model = 1'b0;
    m_rdata   = '0;
    outstanding = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (m_exec === 1'b1 && !reset) begin
        chk("single_outstanding", 64'(outstanding), 0);
        outstanding = 1'b1;
        n_exec++;
        exec_cyc = cyc;
        t_we = m_we; t_addr = m_address; t_data = m_data;
        k = 0;
        do begin
          @(posedge clk); #1;
          k++;
          if (k == 1) chk("exec_pulse_width", 64'(m_exec), 0);
          if (!reset) chk("m_address_held", 64'(m_address), 64'(t_addr));
        end while (!reset && (k < fin_delay || fin_hold) && k < 4000);
        if (!reset) begin
          chk("m_we_held", 64'(m_we), 64'(t_we));
          chk("m_data_held", 64'(m_data), 64'(t_data));
          chk("no_exec_with_fin", 64'(m_exec), 0);
          if (t_we) begin
            mem[t_addr] = t_data;
            m_rdata = 32'hBADC0FFE;
          end else begin
            m_rdata = mem.exists(t_addr) ? mem[t_addr] : 32'h0;
          end
          fin_model = 1'b1;
          @(posedge clk); #1;
          fin_model = 1'b0;
          m_rdata = '0;
        end
        outstanding = 1'b0;
      end
    end
  end

  // Monitor: level model, response hold stability and scoreboard comparison
  int          exp_level = 0;
  bit          push_prev = 1'b0;
  bit          prev_hold = 1'b0;
  logic [36:0] prev_rsp  = '0;
  exp_t        e;
  always @(negedge clk) begin
    if (reset) begin
      exp_level = 0;
      push_prev = 1'b0;
      prev_hold = 1'b0;
    end else begin
      exp_level = exp_level + int'(push_prev) - int'(m_exec);
      chk("level", 64'(level), 64'(exp_level));
      chk("req_ready", 64'(req_ready), 64'(exp_level != int'(DEPTH)));
      push_prev = req_valid && req_ready;
      if (prev_hold) begin
        chk("rsp_hold_valid", 64'(rsp_valid), 1);
        chk("rsp_hold_stable", 64'({rsp_we, rsp_tag, rsp_rdata}), 64'(prev_rsp));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL rsp_unexpected actual=tag %0h required=no response", rsp_tag);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_we", 64'(rsp_we), 64'(e.we));
          chk("rsp_tag", 64'(rsp_tag), 64'(e.tag));
          chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        end
        n_rsp++;
      end
      prev_hold = rsp_valid && !rsp_ready;
      prev_rsp  = {rsp_we, rsp_tag, rsp_rdata};
    end
  end

  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] tag, input logic [31:0] exp_rdata, input bit exp_rsp);
    int n;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_tag = tag;
    n = 0;
    while (!req_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      chk("req_accept", 64'(req_ready), 1);
      req_valid = 1'b0;
      return;
    end
    if (exp_rsp) exp_q.push_back('{we: we, tag: tag, rdata: exp_rdata});
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int n;
    n = 0;
    while (n_rsp < target && n < 300) begin
      @(posedge clk); #2;
      n++;
    end
    chk("rsp_count", 64'(n_rsp), 64'(target));
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk); #2;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  int base;
  int ne;
  int n;
  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_tag = '0; rsp_ready = 1'b0; stray_fin = 1'b0; fin_hold = 1'b0; fin_delay = 5;
    mem[32'h10] = 32'hDEADBEEF;

    // Reset values
    #1;
    chk("rst_req_ready", 64'(req_ready), 1);
    chk("rst_level", 64'(level), 0);
    chk("rst_m_exec", 64'(m_exec), 0);
    chk("rst_rsp_valid", 64'(rsp_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_timeout_err", 64'(timeout_err), 0);
    chk("rst_m_address", 64'(m_address), 0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // Idle, with a stray fin that must be ignored
    repeat (4) @(posedge clk);
    #2 stray_fin = 1'b1;
    @(posedge clk);
    #2 stray_fin = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("idle_no_exec", 64'(n_exec), 0);
    chk("idle_stray_fin_rsp", 64'(rsp_valid), 0);
    chk("idle_busy", 64'(busy), 0);

    // Single read with latency checks
    send(1'b0, 32'h10, 32'h0, 4'd3, 32'hDEADBEEF, 1'b1);
    chk("lat_exec_c0", 64'(m_exec), 0);
    @(posedge clk); #2;
    chk("lat_exec_c1", 64'(m_exec), 1);
    repeat (5) @(posedge clk);
    #2;
    chk("lat_rsp_c6", 64'(rsp_valid), 0);
    chk("m_address_c6", 64'(m_address), 64'h10);
    @(posedge clk); #2;
    chk("lat_rsp_c7", 64'(rsp_valid), 1);
    chk("m_address_cleared", 64'(m_address), 0);
    rsp_ready = 1'b1;
    wait_rsp(1);

    // Back-to-back write then read of the same address
    base = n_rsp; ne = n_exec;
    send(1'b1, 32'h20, 32'h1234, 4'd1, 32'h0, 1'b1);
    send(1'b0, 32'h20, 32'h0, 4'd2, 32'h1234, 1'b1);
    wait_rsp(base + 2);
    chk("b2b_exec_count", 64'(n_exec), 64'(ne + 2));

    // Response backpressure blocks the next issue
    rsp_ready = 1'b0;
    base = n_rsp; ne = n_exec;
    send(1'b0, 32'h10, 32'h0, 4'd4, 32'hDEADBEEF, 1'b1);
    send(1'b0, 32'h20, 32'h0, 4'd5, 32'h1234, 1'b1);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    repeat (10) @(posedge clk);
    #2;
    chk("bp_no_second_exec", 64'(n_exec), 64'(ne + 1));
    chk("bp_rsp_valid", 64'(rsp_valid), 1);
    chk("bp_rsp_tag", 64'(rsp_tag), 4);
    chk("bp_level", 64'(level), 1);
    rsp_ready = 1'b1;
    wait_rsp(base + 2);
    chk("bp_exec_count", 64'(n_exec), 64'(ne + 2));

    // FIFO full with fin withheld, then release with a sixth request waiting
    fin_delay = 3;
    fin_hold = 1'b1;
    base = n_rsp; ne = n_exec;
    send(1'b1, 32'h100, 32'h0000000A, 4'd6, 32'h0, 1'b1);
    send(1'b0, 32'h100, 32'h0, 4'd7, 32'h0000000A, 1'b1);
    send(1'b1, 32'h104, 32'h0000000C, 4'd8, 32'h0, 1'b1);
    send(1'b0, 32'h104, 32'h0, 4'd9, 32'h0000000C, 1'b1);
    send(1'b0, 32'h10, 32'h0, 4'd10, 32'hDEADBEEF, 1'b1);
    chk("full_level", 64'(level), 4);
    chk("full_req_ready", 64'(req_ready), 0);
    fork
      begin
        @(posedge clk);
        #3 fin_hold = 1'b0;
      end
    join_none
    send(1'b1, 32'h108, 32'h55, 4'd11, 32'h0, 1'b1);
    wait_rsp(base + 6);
    chk("full_exec_count", 64'(n_exec), 64'(ne + 6));

    // Timeout, then reset in the middle of WAIT
    fin_delay = 5;
    chk("pre_tmo_err", 64'(timeout_err), 0);
    chk("pre_tmo_busy", 64'(busy), 0);
    fin_hold = 1'b1;
    ne = n_exec;
    send(1'b0, 32'h40, 32'h0, 4'd12, 32'h0, 1'b0);
    n = 0;
    while (n_exec == ne && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    chk("tmo_exec_seen", 64'(n_exec), 64'(ne + 1));
    send(1'b0, 32'h44, 32'h0, 4'd13, 32'h0, 1'b0);
    send(1'b0, 32'h48, 32'h0, 4'd14, 32'h0, 1'b0);
    wait_cyc(exec_cyc + 5);
    chk("tmo_err_early", 64'(timeout_err), 0);
    wait_cyc(exec_cyc + 12);
    chk("tmo_err_set", 64'(timeout_err), 1);
    wait_cyc(exec_cyc + 15);
    chk("tmo_err_sticky", 64'(timeout_err), 1);
    chk("tmo_level", 64'(level), 2);
    chk("tmo_busy", 64'(busy), 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_err", 64'(timeout_err), 0);
    chk("mid_rst_level", 64'(level), 0);
    chk("mid_rst_m_exec", 64'(m_exec), 0);
    chk("mid_rst_req_ready", 64'(req_ready), 1);
    chk("mid_rst_busy", 64'(busy), 0);
    exp_q.delete();
    fin_hold = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    chk("post_rst_no_exec", 64'(n_exec), 64'(ne + 1));
    chk("post_rst_level", 64'(level), 0);
    chk("post_rst_err", 64'(timeout_err), 0);
    chk("post_rst_rsp_valid", 64'(rsp_valid), 0);

    chk("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
